// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one UART transmitter among four requesters
//
// Grants the transmitter to one requester per message. A grant starts with a
// round-robin pick, lasts until the owner drops req, goes idle for TIMEOUT
// cycles, or sends MAX_BYTES bytes, and is followed by one GAP cycle.
//
// Ports:
//   clk             in   clock, rising edge
//   rst             in   synchronous active-high reset
//   req[3:0]        in   per-requester request to own the transmitter
//   req_tx_data     in   per-requester byte, requester i on [8i+7:8i]
//   req_new_tx_data in   per-requester byte-valid strobe
//   gnt[3:0]        out  registered one-hot grant, or zero
//   req_tx_busy     out  per-requester busy (owner sees tx_busy, others 1)
//   tx_data[7:0]    out  byte to the transmitter
//   new_tx_data     out  byte strobe to the transmitter
//   tx_busy         in   transmitter busy
module uart_tx_arbiter #(
  parameter int TIMEOUT   = 1000,
  parameter int MAX_BYTES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [31:0] req_tx_data,
  input  logic [3:0]  req_new_tx_data,
  output logic [3:0]  gnt,
  output logic [3:0]  req_tx_busy,
  output logic [7:0]  tx_data,
  output logic        new_tx_data,
  input  logic        tx_busy
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_OWNED = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  // Idle counter value on the cycle whose increment completes TIMEOUT idle cycles.
  localparam logic [15:0] IDLE_LIMIT    = 16'(TIMEOUT - 1);
  localparam logic [8:0]  BYTE_LIMIT    = 9'(MAX_BYTES);
  localparam bit          BYTE_LIMIT_EN = (MAX_BYTES != 0);

  logic [1:0]  state_q, state_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [1:0]  own_q, own_d;
  logic [3:0]  gnt_q, gnt_d;
  logic [7:0]  byte_cnt_q, byte_cnt_d;
  logic [15:0] idle_cnt_q, idle_cnt_d;

  logic        owned;
  logic        accept;
  logic        release_now;
  logic        found;
  logic [1:0]  pick;

  assign owned  = (state_q == ST_OWNED);
  // Reset gating keeps the transmitter quiet during the cycle rst is sampled.
  assign accept = owned & ~rst & req_new_tx_data[own_q] & ~tx_busy;

  // An unexpected state encoding never presents a grant.
  assign gnt         = owned ? gnt_q : 4'b0000;
  assign new_tx_data = accept;
  assign tx_data     = owned ? req_tx_data[{own_q, 3'b000} +: 8] : 8'h00;
  assign req_tx_busy = (owned & ~rst) ? (~gnt_q | {4{tx_busy}}) : 4'b1111;

  // First requester at or above ptr, wrapping modulo 4.
  always_comb begin
    found = 1'b0;
    pick  = ptr_q;
    for (int k = 0; k < 4; k++) begin
      if (!found && req[ptr_q + 2'(k)]) begin
        found = 1'b1;
        pick  = ptr_q + 2'(k);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    own_d       = own_q;
    gnt_d       = gnt_q;
    byte_cnt_d  = byte_cnt_q;
    idle_cnt_d  = idle_cnt_q;
    release_now = 1'b0;

    case (state_q)
      ST_OWNED: begin
        if (accept) begin
          // A byte accepted while req falls is still forwarded; release
          // is decided on a later cycle once req is seen low again.
          byte_cnt_d = byte_cnt_q + 8'd1;
          idle_cnt_d = 16'd0;
          if (BYTE_LIMIT_EN && (({1'b0, byte_cnt_q} + 9'd1) == BYTE_LIMIT)) begin
            release_now = 1'b1;
          end
        end else if (!req[own_q]) begin
          release_now = 1'b1;
        end else if (!tx_busy) begin
          idle_cnt_d = idle_cnt_q + 16'd1;
          if (idle_cnt_q == IDLE_LIMIT) begin
            release_now = 1'b1;
          end
        end

        if (release_now) begin
          state_d = ST_GAP;
          gnt_d   = 4'b0000;
          ptr_d   = own_q + 2'd1;
        end
      end

      ST_GAP: begin
        state_d = ST_IDLE;
        gnt_d   = 4'b0000;
      end

      default: begin
        // IDLE, and any illegal encoding recovers through the same path.
        gnt_d   = 4'b0000;
        state_d = ST_IDLE;
        if (found) begin
          state_d    = ST_OWNED;
          own_d      = pick;
          gnt_d      = 4'b0001 << pick;
          byte_cnt_d = 8'd0;
          idle_cnt_d = 16'd0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ptr_q      <= 2'd0;
      own_q      <= 2'd0;
      gnt_q      <= 4'b0000;
      byte_cnt_q <= 8'd0;
      idle_cnt_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      own_q      <= own_d;
      gnt_q      <= gnt_d;
      byte_cnt_q <= byte_cnt_d;
      idle_cnt_q <= idle_cnt_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

  localparam int TIMEOUT   = 1000;
  localparam int MAX_BYTES = 2;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_tx_data;
  logic [3:0]  req_new_tx_data;
  logic [3:0]  gnt;
  logic [3:0]  req_tx_busy;
  logic [7:0]  tx_data;
  logic        new_tx_data;
  logic        tx_busy;

  int n_vec = 0;
  int n_bad = 0;

  uart_tx_arbiter #(.TIMEOUT(TIMEOUT), .MAX_BYTES(MAX_BYTES)) dut (
    .clk             (clk),
    .rst             (rst),
    .req             (req),
    .req_tx_data     (req_tx_data),
    .req_new_tx_data (req_new_tx_data),
    .gnt             (gnt),
    .req_tx_busy     (req_tx_busy),
    .tx_data         (tx_data),
    .new_tx_data     (new_tx_data),
    .tx_busy         (tx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: who owns the transmitter (-1 = nobody), whether the gap
  // cycle is running, the round-robin start point and per-grant tallies.
  int m_owner, m_gap, m_ptr, m_bytes, m_idle;
  logic [3:0] e_gnt, e_rtb;
  logic       e_ntd;
  logic [7:0] e_txd;

  task automatic model_reset();
    m_owner = -1; m_gap = 0; m_ptr = 0; m_bytes = 0; m_idle = 0;
  endtask

  task automatic model_eval();
    e_gnt = 4'h0; e_txd = 8'h00; e_ntd = 1'b0; e_rtb = 4'hF;
    if (m_owner >= 0) begin
      e_gnt = 4'(1 << m_owner);
      e_txd = req_tx_data[8*m_owner +: 8];
      e_ntd = !rst && req_new_tx_data[m_owner] && !tx_busy;
      if (!rst) e_rtb[m_owner] = tx_busy;
    end
  endtask

  task automatic model_update();
    bit acc, rel;
    if (rst) begin
      model_reset();
    end else if (m_gap != 0) begin
      m_gap = 0;
    end else if (m_owner < 0) begin
      for (int k = 0; k < 4; k++) begin
        if (m_owner < 0 && req[(m_ptr + k) % 4]) begin
          m_owner = (m_ptr + k) % 4;
          m_bytes = 0;
          m_idle  = 0;
        end
      end
    end else begin
      acc = req_new_tx_data[m_owner] && !tx_busy;
      rel = 0;
      if (acc) begin
        m_bytes++;
        m_idle = 0;
        if (MAX_BYTES != 0 && m_bytes == MAX_BYTES) rel = 1;
      end else if (!req[m_owner]) begin
        rel = 1;
      end else if (!tx_busy) begin
        m_idle++;
        if (m_idle == TIMEOUT) rel = 1;
      end
      if (rel) begin
        m_ptr   = (m_owner + 1) % 4;
        m_owner = -1;
        m_gap   = 1;
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs after the falling edge, then compare all
  // outputs against the reference once they have settled.
  task automatic drive(input logic r, input logic [3:0] rq, input logic [31:0] d,
                       input logic [3:0] n, input logic b);
    @(negedge clk);
    rst = r; req = rq; req_tx_data = d; req_new_tx_data = n; tx_busy = b;
    #1;
    model_eval();
    check("model{gnt,busy,strobe,data}",
          {15'b0, gnt, req_tx_busy, new_tx_data, tx_data},
          {15'b0, e_gnt, e_rtb, e_ntd, e_txd});
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
  endtask

  task automatic step(input logic r, input logic [3:0] rq, input logic [31:0] d,
                      input logic [3:0] n, input logic b);
    drive(r, rq, d, n, b);
    tick();
  endtask

  typedef struct {
    logic        r;
    logic [3:0]  rq;
    logic [31:0] d;
    logic [3:0]  n;
    logic        b;
    logic [3:0]  gnt;
    logic [3:0]  rtb;
    logic        ntd;
    logic [7:0]  txd;
  } vec_t;

  vec_t tbl[21];

  initial begin
    bit ok;
    logic [3:0] cur_req;

    //            r  req      data          strobe   busy gnt      rtb      ntd   txd
    tbl[0]  = '{1'b1, 4'b0000, 32'h0,        4'b0000, 1'b0, 4'b0000, 4'b1111, 1'b0, 8'h00};
    tbl[1]  = '{1'b0, 4'b0110, 32'h0,        4'b0000, 1'b0, 4'b0000, 4'b1111, 1'b0, 8'h00};
    tbl[2]  = '{1'b0, 4'b0110, 32'h0,        4'b0000, 1'b0, 4'b0010, 4'b1101, 1'b0, 8'h00};
    tbl[3]  = '{1'b0, 4'b0100, 32'h0,        4'b0000, 1'b0, 4'b0010, 4'b1101, 1'b0, 8'h00};
    tbl[4]  = '{1'b0, 4'b0100, 32'h0,        4'b0000, 1'b0, 4'b0000, 4'b1111, 1'b0, 8'h00};
    tbl[5]  = '{1'b0, 4'b0100, 32'h0,        4'b0000, 1'b0, 4'b0000, 4'b1111, 1'b0, 8'h00};
    tbl[6]  = '{1'b0, 4'b0100, 32'h0,        4'b0000, 1'b0, 4'b0100, 4'b1011, 1'b0, 8'h00};
    tbl[7]  = '{1'b0, 4'b0000, 32'h0,        4'b0000, 1'b0, 4'b0100, 4'b1011, 1'b0, 8'h00};
    tbl[8]  = '{1'b0, 4'b0000, 32'h0,        4'b0000, 1'b0, 4'b0000, 4'b1111, 1'b0, 8'h00};
    tbl[9]  = '{1'b0, 4'b0010, 32'h0,        4'b0000, 1'b0, 4'b0000, 4'b1111, 1'b0, 8'h00};
    tbl[10] = '{1'b0, 4'b1010, 32'h41002200, 4'b1000, 1'b0, 4'b0010, 4'b1101, 1'b0, 8'h22};
    tbl[11] = '{1'b0, 4'b1010, 32'h41002200, 4'b1010, 1'b0, 4'b0010, 4'b1101, 1'b1, 8'h22};
    tbl[12] = '{1'b0, 4'b1010, 32'h41002200, 4'b1000, 1'b1, 4'b0010, 4'b1111, 1'b0, 8'h22};
    tbl[13] = '{1'b0, 4'b1000, 32'h41002200, 4'b1000, 1'b0, 4'b0010, 4'b1101, 1'b0, 8'h22};
    tbl[14] = '{1'b0, 4'b1000, 32'h0,        4'b0000, 1'b0, 4'b0000, 4'b1111, 1'b0, 8'h00};
    tbl[15] = '{1'b0, 4'b1000, 32'h0,        4'b0000, 1'b0, 4'b0000, 4'b1111, 1'b0, 8'h00};
    tbl[16] = '{1'b0, 4'b1000, 32'h41000000, 4'b0000, 1'b0, 4'b1000, 4'b0111, 1'b0, 8'h41};
    tbl[17] = '{1'b0, 4'b0000, 32'h68000000, 4'b1000, 1'b0, 4'b1000, 4'b0111, 1'b1, 8'h68};
    tbl[18] = '{1'b0, 4'b0000, 32'h68000000, 4'b0000, 1'b0, 4'b1000, 4'b0111, 1'b0, 8'h68};
    tbl[19] = '{1'b0, 4'b0000, 32'h0,        4'b0000, 1'b0, 4'b0000, 4'b1111, 1'b0, 8'h00};
    tbl[20] = '{1'b0, 4'b0000, 32'h0,        4'b0000, 1'b0, 4'b0000, 4'b1111, 1'b0, 8'h00};

    rst = 1'b1; req = 4'h0; req_tx_data = 32'h0; req_new_tx_data = 4'h0; tx_busy = 1'b0;
    repeat (3) @(posedge clk);
    model_reset();

    // Directed table: two-requester handover, foreign strobe, byte with req falling.
    for (int i = 0; i < 21; i++) begin
      drive(tbl[i].r, tbl[i].rq, tbl[i].d, tbl[i].n, tbl[i].b);
      check($sformatf("tbl[%0d].gnt", i), {28'b0, gnt}, {28'b0, tbl[i].gnt});
      check($sformatf("tbl[%0d].req_tx_busy", i), {28'b0, req_tx_busy}, {28'b0, tbl[i].rtb});
      check($sformatf("tbl[%0d].new_tx_data", i), {31'b0, new_tx_data}, {31'b0, tbl[i].ntd});
      check($sformatf("tbl[%0d].tx_data", i), {24'b0, tx_data}, {24'b0, tbl[i].txd});
      tick();
    end

    // Round robin, all requesting, each owner sends MAX_BYTES bytes.
    step(1'b1, 4'h0, 32'h0, 4'h0, 1'b0);
    for (int k = 0; k < 20; k++) begin
      logic [3:0] exp_g;
      exp_g = ((k % 4) == 1 || (k % 4) == 2) ? 4'(1 << ((k / 4) % 4)) : 4'h0;
      drive(1'b0, 4'hF, $urandom, 4'hF, 1'b0);
      check($sformatf("rr_gnt[%0d]", k), {28'b0, gnt}, {28'b0, exp_g});
      tick();
    end

    // Busy never times out; idle releases after exactly TIMEOUT cycles.
    step(1'b1, 4'h0, 32'h0, 4'h0, 1'b0);
    step(1'b0, 4'b0100, 32'h0, 4'h0, 1'b0);
    ok = 1;
    for (int t = 0; t < 5000; t++) begin
      drive(1'b0, 4'b0100, 32'h0, 4'h0, 1'b1);
      if (gnt !== 4'b0100) ok = 0;
      tick();
    end
    check("busy_hold", {31'b0, ok}, 32'd1);
    ok = 1;
    for (int t = 0; t < TIMEOUT; t++) begin
      drive(1'b0, 4'b0100, 32'h0, 4'h0, 1'b0);
      if (gnt !== 4'b0100) ok = 0;
      tick();
    end
    check("idle_hold", {31'b0, ok}, 32'd1);
    drive(1'b0, 4'b0100, 32'h0, 4'h0, 1'b0);
    check("timeout_release", {28'b0, gnt}, 32'h0);
    tick();

    // Reset in the middle of a message.
    step(1'b1, 4'h0, 32'h0, 4'h0, 1'b0);
    step(1'b0, 4'b0100, 32'h0, 4'h0, 1'b0);
    drive(1'b0, 4'b0100, 32'h00AA0000, 4'b0100, 1'b0);
    check("pre_rst_strobe", {31'b0, new_tx_data}, 32'd1);
    tick();
    drive(1'b1, 4'b0100, 32'h00AA0000, 4'b0100, 1'b0);
    check("rst_strobe", {31'b0, new_tx_data}, 32'd0);
    check("rst_busy", {28'b0, req_tx_busy}, 32'hF);
    tick();
    drive(1'b0, 4'b1000, 32'h0, 4'h0, 1'b0);
    check("post_rst_gnt", {28'b0, gnt}, 32'h0);
    tick();
    drive(1'b0, 4'b1000, 32'h0, 4'h0, 1'b0);
    check("post_rst_regrant", {28'b0, gnt}, 32'h8);
    tick();

    // Random traffic against the reference.
    cur_req = 4'h0;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 4; b++) if ($urandom_range(7) == 0) cur_req[b] = ~cur_req[b];
      step(($urandom_range(199) == 0), cur_req, $urandom, 4'($urandom), ($urandom_range(2) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
